// File: rtl/alarm_signal_driver.sv
// alarm_signal_driver
//   Turns a single-cycle start pulse into a repeating alarm pattern: groups of
//   BEEPS tone bursts separated by OFF gaps, with a longer silent GAP after
//   each group. Repeats until a stop pulse, a reset, or MAX_BURSTS groups have
//   played (MAX_BURSTS = 0 repeats forever).
//
// Ports
//   clk_i     system clock, everything on the rising edge
//   rst_ni    synchronous active-low reset
//   start_i   1-cycle trigger pulse, ignored while the pattern is running
//   stop_i    1-cycle stop pulse, aborts the pattern at the next edge
//   buzzer_o  square wave (half-period TONE_HALF clocks) while in ON, else 0
//   led_o     1 while in ON
//   active_o  1 while in ON, OFF or GAP
//   done_o    1-cycle pulse when the pattern ends after MAX_BURSTS groups
//
// State | meaning
// ------+-------------------------------------------------------------
// IDLE  | silent, waiting for start
// ON    | tone burst, led lit, buzzer toggling
// OFF   | silence between beeps of one group
// GAP   | silence after the last beep of a group
module alarm_signal_driver #(
  parameter int unsigned ON_CYCLES  = 50_000_000,
  parameter int unsigned OFF_CYCLES = 25_000_000,
  parameter int unsigned GAP_CYCLES = 100_000_000,
  parameter int unsigned BEEPS      = 3,
  parameter int unsigned MAX_BURSTS = 30,
  parameter int unsigned TONE_HALF  = 25_000
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic start_i,
  input  logic stop_i,
  output logic buzzer_o,
  output logic led_o,
  output logic active_o,
  output logic done_o
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ON   = 2'd1;
  localparam logic [1:0] ST_OFF  = 2'd2;
  localparam logic [1:0] ST_GAP  = 2'd3;

  localparam int unsigned MAX_ON_OFF = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
  localparam int unsigned MAX_CYC    = (MAX_ON_OFF > GAP_CYCLES) ? MAX_ON_OFF : GAP_CYCLES;

  localparam int PH_W    = $clog2(MAX_CYC) + 1;
  localparam int BEEP_W  = $clog2(BEEPS) + 1;
  // With no burst limit the counter only needs to saturate, so a byte is plenty.
  localparam int BURST_W = (MAX_BURSTS == 0) ? 8 : $clog2(MAX_BURSTS) + 1;
  localparam int TONE_W  = $clog2(TONE_HALF) + 1;

  localparam logic [PH_W-1:0]    ON_LAST    = PH_W'(ON_CYCLES - 1);
  localparam logic [PH_W-1:0]    OFF_LAST   = PH_W'(OFF_CYCLES - 1);
  localparam logic [PH_W-1:0]    GAP_LAST   = PH_W'(GAP_CYCLES - 1);
  localparam logic [BEEP_W-1:0]  BEEP_LAST  = BEEP_W'(BEEPS - 1);
  localparam logic [BURST_W-1:0] BURST_LAST = (MAX_BURSTS == 0) ? '0 : BURST_W'(MAX_BURSTS - 1);
  localparam logic [BURST_W-1:0] BURST_SAT  = {BURST_W{1'b1}};
  localparam logic [TONE_W-1:0]  TONE_LAST  = TONE_W'(TONE_HALF - 1);

  logic [1:0]         state_q,  state_d;
  logic [PH_W-1:0]    phase_q,  phase_d;
  logic [BEEP_W-1:0]  beep_q,   beep_d;
  logic [BURST_W-1:0] burst_q,  burst_d;
  logic [TONE_W-1:0]  tone_q,   tone_d;
  logic               tone_lvl_q, tone_lvl_d;
  logic               led_q,    led_d;
  logic               active_q, active_d;
  logic               done_q,   done_d;

  // ------------------------------------------------------------------
  // Pattern sequencing
  // ------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    phase_d = phase_q + 1'b1;
    beep_d  = beep_q;
    burst_d = burst_q;
    done_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        phase_d = '0;
        if (start_i && !stop_i) begin
          state_d = ST_ON;
          beep_d  = '0;
          burst_d = '0;
        end
      end

      ST_ON: begin
        if (phase_q == ON_LAST) begin
          phase_d = '0;
          state_d = (beep_q == BEEP_LAST) ? ST_GAP : ST_OFF;
        end
      end

      ST_OFF: begin
        if (phase_q == OFF_LAST) begin
          phase_d = '0;
          state_d = ST_ON;
          beep_d  = beep_q + 1'b1;
        end
      end

      ST_GAP: begin
        if (phase_q == GAP_LAST) begin
          phase_d = '0;
          if ((MAX_BURSTS != 0) && (burst_q == BURST_LAST)) begin
            state_d = ST_IDLE;
            beep_d  = '0;
            burst_d = '0;
            done_d  = 1'b1;
          end else begin
            state_d = ST_ON;
            beep_d  = '0;
            if (burst_q != BURST_SAT) begin
              burst_d = burst_q + 1'b1;
            end
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
        phase_d = '0;
        beep_d  = '0;
        burst_d = '0;
      end
    endcase

    // Stop wins over every transition above, including the final GAP exit,
    // so an aborted pattern never reports done.
    if (stop_i && (state_q != ST_IDLE)) begin
      state_d = ST_IDLE;
      phase_d = '0;
      beep_d  = '0;
      burst_d = '0;
      done_d  = 1'b0;
    end
  end

  // ------------------------------------------------------------------
  // Buzzer tone: level starts high on each ON entry, toggles every
  // TONE_HALF clocks while ON stays, and is forced low elsewhere.
  // ------------------------------------------------------------------
  always_comb begin
    tone_d     = '0;
    tone_lvl_d = 1'b0;
    if (state_d == ST_ON) begin
      if (state_q != ST_ON) begin
        tone_d     = '0;
        tone_lvl_d = 1'b1;
      end else if (tone_q == TONE_LAST) begin
        tone_d     = '0;
        tone_lvl_d = ~tone_lvl_q;
      end else begin
        tone_d     = tone_q + 1'b1;
        tone_lvl_d = tone_lvl_q;
      end
    end
  end

  // Outputs are decoded from next-state values and registered, giving one
  // cycle of latency from a start/stop edge with no input-to-output path.
  always_comb begin
    led_d    = (state_d == ST_ON);
    active_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q    <= ST_IDLE;
      phase_q    <= '0;
      beep_q     <= '0;
      burst_q    <= '0;
      tone_q     <= '0;
      tone_lvl_q <= 1'b0;
      led_q      <= 1'b0;
      active_q   <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      beep_q     <= beep_d;
      burst_q    <= burst_d;
      tone_q     <= tone_d;
      tone_lvl_q <= tone_lvl_d;
      led_q      <= led_d;
      active_q   <= active_d;
      done_q     <= done_d;
    end
  end

  assign buzzer_o = tone_lvl_q;
  assign led_o    = led_q;
  assign active_o = active_q;
  assign done_o   = done_q;

endmodule
